// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: drives the next PC, issues in-order fetches to a
// variable-latency memory and buffers PC-tagged instructions for decode.
module fetch_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    RESET_WAIT,
    FETCH,
    HALT
  } state_t;

  state_t        state, state_nxt;
  logic          misalign_nxt;

  logic [31:0]   slot_pc   [DEPTH];
  logic [31:0]   slot_data [DEPTH];

  logic [PW-1:0] head, tail, fill_ptr;
  logic [PW-1:0] head_nxt, tail_nxt, fill_ptr_nxt;
  // unfill_cnt counts allocated slots still waiting for their response
  logic [CW-1:0] alloc_cnt, unfill_cnt, drop_cnt;
  logic [CW-1:0] alloc_nxt, unfill_nxt, drop_nxt, unfill_after;

  logic [CW:0]   inflight;
  logic          req_fire, resp_fill, resp_drop, pop, head_filled;

  assign inflight       = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req_valid = !rst && (state == FETCH) && !redirect_valid && (inflight < DEPTH_W);
  assign imem_req_addr  = pc_cur;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign resp_drop      = imem_resp_valid & (drop_cnt != '0);
  assign resp_fill      = imem_resp_valid & (drop_cnt == '0);

  assign head_filled    = alloc_cnt > unfill_cnt;
  assign instr_valid    = !rst && head_filled && !redirect_valid;
  assign pop            = instr_valid & instr_ready;
  assign instr_data     = slot_data[head];
  assign instr_pc       = slot_pc[head];

  always_comb begin
    pc_next = pc_cur;
    if (rst)                 pc_next = pc_cur;
    else if (redirect_valid) pc_next = redirect_pc;
    else if (req_fire)       pc_next = pc_cur + 32'd4;
  end

  always_comb begin
    state_nxt    = state;
    misalign_nxt = misalign_err;
    case (state)
      RESET_WAIT: state_nxt = FETCH;
      FETCH: begin
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          state_nxt    = HALT;
          misalign_nxt = 1'b1;
        end
      end
      HALT: begin
        if (redirect_valid && (redirect_pc[1:0] == 2'b00)) begin
          state_nxt    = FETCH;
          misalign_nxt = 1'b0;
        end
      end
      default: state_nxt = RESET_WAIT;
    endcase
  end

  // The response is applied before the flush, so its slot never becomes a drop credit
  always_comb begin
    unfill_after = unfill_cnt - CW'(resp_fill);
    head_nxt     = head;
    tail_nxt     = tail;
    fill_ptr_nxt = fill_ptr;
    alloc_nxt    = alloc_cnt;
    unfill_nxt   = unfill_cnt;
    drop_nxt     = drop_cnt - CW'(resp_drop);
    if (redirect_valid) begin
      head_nxt     = '0;
      tail_nxt     = '0;
      fill_ptr_nxt = '0;
      alloc_nxt    = '0;
      unfill_nxt   = '0;
      drop_nxt     = drop_cnt - CW'(resp_drop) + unfill_after;
    end else begin
      head_nxt     = head + PW'(pop);
      tail_nxt     = tail + PW'(req_fire);
      fill_ptr_nxt = fill_ptr + PW'(resp_fill);
      alloc_nxt    = alloc_cnt + CW'(req_fire) - CW'(pop);
      unfill_nxt   = unfill_after + CW'(req_fire);
    end
  end

  // Registered control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESET_WAIT;
      misalign_err <= 1'b0;
      head         <= '0;
      tail         <= '0;
      fill_ptr     <= '0;
      alloc_cnt    <= '0;
      unfill_cnt   <= '0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_nxt;
      misalign_err <= misalign_nxt;
      head         <= head_nxt;
      tail         <= tail_nxt;
      fill_ptr     <= fill_ptr_nxt;
      alloc_cnt    <= alloc_nxt;
      unfill_cnt   <= unfill_nxt;
      drop_cnt     <= drop_nxt;
    end
  end

  // Slot payload; validity lives entirely in the counters above
  always_ff @(posedge clk) begin
    if (req_fire)  slot_pc[tail]       <= pc_cur;
    if (resp_fill) slot_data[fill_ptr] <= imem_resp_data;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch controller between the PC register and instruction memory.
- Consumes the current PC and produces the next PC, which the PC register loads every cycle.
- Issues in-order requests to a variable-latency instruction memory and buffers returned instructions, tagged with their PC, for decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing its buffer and discarding stale responses.

Parameters:
DEPTH, 4, fetch buffer entries (power of two, >=2); also the maximum number of outstanding requests plus pending drops

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
pc_cur  input  32  current PC from the PC register
pc_next  output  32  next PC, drives the PC register input
redirect_valid  input  1  branch/jump taken; redirect_pc is valid
redirect_pc  input  32  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  32  fetch address (= pc_cur)
imem_resp_valid  input  1  response data valid; responses return in request order, no backpressure
imem_resp_data  input  32  fetched instruction
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts
instr_data  output  32  instruction word
instr_pc  output  32  PC of instr_data
misalign_err  output  1  sticky; redirect target not word aligned

Behaviour:
- Reset: state=RESET_WAIT, buffer empty, drop_cnt=0, misalign_err=0, imem_req_valid=0, instr_valid=0. pc_next=pc_cur during rst.
- FSM states:
  - RESET_WAIT: one cycle after rst deasserts; no requests; goes to FETCH.
  - FETCH: normal issue.
  - HALT: no requests issued.
  - FETCH->HALT on a redirect with redirect_pc[1:0]!=0; misalign_err is set on that same edge. In HALT, an aligned redirect clears misalign_err and returns to FETCH.
- Buffer: circular, DEPTH slots, each {pc, data, filled}.
  - On a request handshake (imem_req_valid & imem_req_ready), allocate the tail slot with pc=pc_cur, filled=0.
  - A response fills the oldest unfilled slot.
  - instr_valid = head slot allocated and filled. The head pops on instr_valid & instr_ready.
  - Same-cycle allocate, fill and pop are all legal.
- Issue: imem_req_valid = (state==FETCH) & !redirect_valid & (alloc_cnt + drop_cnt < DEPTH). This guarantees every response has a slot or a drop credit. There is no combinational path from imem_req_ready to imem_req_valid.
- pc_next priority:
  - redirect_valid (any state, including misaligned): redirect_pc.
  - Else request handshake: pc_cur+4, with 32-bit wrap (0xFFFFFFFC -> 0x0).
  - Else: pc_cur (hold).
- Response ordering within a cycle: the response is applied first. If drop_cnt>0, it decrements drop_cnt and is discarded; otherwise it fills a slot. Flush is applied after.
- Redirect (flush):
  - All slots are invalidated.
  - drop_cnt_next = drop_cnt + (allocated-but-unfilled slots after this cycle's response).
  - instr_valid is forced 0 in the redirect cycle and no pop occurs.
  - No request is issued that cycle. Fetch from redirect_pc starts the next cycle.
- Latency:
  - Request is issued in the cycle pc_cur is presented, if ready.
  - Response at cycle N gives instr_valid at N+1 at the earliest (registered fill, no bypass).
- Full buffer: requests stall, pc_next holds, and data already buffered remains valid until decode accepts it.
- Decode stall: head data/pc are held stable while instr_valid & !instr_ready.
- A response with no outstanding request or drop is a protocol error. Behaviour is undefined; the bench asserts it never happens.
- Reset mid-operation: all counters and the buffer clear at the reset edge. Responses arriving after reset belong to the memory, which shares rst.

Test Plan:
- Reset, imem_req_ready=1, memory latency 1 -> requests at 0x0, 0x4, 0x8...; instr_pc/instr_data stream in order, one per cycle after fill latency.
- instr_ready=0 held, latency 1 -> exactly 4 requests issued, then imem_req_valid=0 and pc_next=pc_cur=0x10; releasing instr_ready resumes issue at 0x10.
- Latency 3, redirect to 0x100 while 2 requests are outstanding -> those 2 responses discarded (drop_cnt 2->0), next instr_pc=0x100, no stale instruction is presented.
- Redirect in the same cycle as a response and a decode stall -> instr_valid=0 that cycle, response dropped, pc_next=redirect_pc.
- Redirect to 0x102 -> misalign_err=1 next cycle, no further requests; redirect to 0x200 -> error clears and fetch resumes at 0x200.
- pc_cur=0xFFFFFFFC accepted -> pc_next=0x00000000.
